// File: rtl/lz77_decoder_param.sv
// LZ77 code-triple decoder with a shifting search buffer.
// Optional position range check: define LZ77_DEC_POSCHK_EN.
module lz77_decoder_param #(
  parameter int SYM_W = 8,
  parameter int SB_DEPTH = 9,
  parameter int LEN_MAX = 7,
  parameter logic [SYM_W-1:0] END_SYM = 8'h24,
  localparam int POS_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1,
  localparam int LEN_W = ($clog2(LEN_MAX + 1) > 0) ? $clog2(LEN_MAX + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  output logic             code_ready,
  input  logic [POS_W-1:0] code_pos,
  input  logic [LEN_W-1:0] code_len,
  input  logic [SYM_W-1:0] chardata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] char_nxt,
  output logic             finish,
  output logic             pos_err
);

`ifdef LZ77_DEC_POSCHK_EN
  localparam bit POSCHK = 1'b1;
`else
  localparam bit POSCHK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    LIT,
    DONE
  } state_t;

  state_t           state;
  logic [SYM_W-1:0] sb      [SB_DEPTH];
  logic [SYM_W-1:0] sb_next [SB_DEPTH];
  logic [POS_W-1:0] pos;
  logic [LEN_W-1:0] cnt;
  logic [SYM_W-1:0] lit;
  logic             pos_err_q;
  logic             acc_rng;
  logic             lat_rng;
  logic [SYM_W-1:0] acc_sym;
  logic [SYM_W-1:0] nxt_sym;

  assign pos_err = pos_err_q;

  // Buffer as it will be once the presented symbol is consumed.
  always_comb begin
    sb_next[0] = char_nxt;
    for (int i = 1; i < SB_DEPTH; i++) begin
      sb_next[i] = sb[i-1];
    end
  end

  assign acc_rng = int'(code_pos) < SB_DEPTH;
  assign lat_rng = int'(pos) < SB_DEPTH;
  assign acc_sym = acc_rng ? sb[code_pos] : '0;
  assign nxt_sym = lat_rng ? sb_next[pos] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb[i] <= '0;
      end
      pos        <= '0;
      cnt        <= '0;
      lit        <= '0;
      out_valid  <= 1'b0;
      char_nxt   <= '0;
      finish     <= 1'b0;
      pos_err_q  <= 1'b0;
      code_ready <= 1'b1;
    end else begin
      pos_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (code_valid) begin
            pos        <= code_pos;
            lit        <= chardata;
            cnt        <= code_len;
            code_ready <= 1'b0;
            out_valid  <= 1'b1;
            pos_err_q  <= POSCHK && !acc_rng;
            if (code_len != '0 && !(POSCHK && !acc_rng)) begin
              state    <= COPY;
              char_nxt <= acc_sym;
              finish   <= 1'b0;
            end else begin
              state    <= LIT;
              char_nxt <= chardata;
              finish   <= (chardata == END_SYM);
            end
          end
        end
        COPY: begin
          if (out_ready) begin
            sb  <= sb_next;
            cnt <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) begin
              state    <= LIT;
              char_nxt <= lit;
              finish   <= (lit == END_SYM);
            end else begin
              char_nxt <= nxt_sym;
            end
          end
        end
        LIT: begin
          if (out_ready) begin
            sb        <= sb_next;
            out_valid <= 1'b0;
            finish    <= 1'b0;
            if (finish) begin
              state <= DONE;
            end else begin
              state      <= IDLE;
              code_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          out_valid  <= 1'b0;
          code_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
